// File: rtl/ucdp_sfifo_unpack.sv
// FIFO read-side unpacker: pops wide words and serialises them into
// dwidth_p/owidth_p narrow slices on a valid/ready stream.
module ucdp_sfifo_unpack #(
    parameter int unsigned dwidth_p    = 32,
    parameter int unsigned owidth_p    = 8,
    parameter bit          msb_first_p = 1'b0
) (
    input  logic                src_clk_i,
    input  logic                src_rst_an_i,
    input  logic                flush_i,
    output logic                rd_en_o,
    input  logic [dwidth_p-1:0] rd_data_i,
    input  logic                rd_empty_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [owidth_p-1:0] out_data_o,
    output logic                out_last_o,
    output logic                busy_o
);

    localparam int unsigned RATIO = (owidth_p >= 1) ? dwidth_p / owidth_p : 1;
    localparam int unsigned IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDXW-1:0] LASTIDX = IDXW'(RATIO - 1);

    generate
        if ((owidth_p < 1) || ((dwidth_p % owidth_p) != 0) || (RATIO < 1)) begin : g_bad_params
            $error("ucdp_sfifo_unpack: dwidth_p must be a non-zero multiple of owidth_p");
        end
    endgenerate

    logic [dwidth_p-1:0] r_word;
    logic [IDXW-1:0]     r_idx;
    logic                r_have;

    logic                w_acc;
    logic                w_last;
    logic                w_done;
    logic                w_pop;
    logic [IDXW-1:0]     w_k;
    logic [owidth_p-1:0] w_slice;

    assign w_acc  = r_have & out_ready_i;
    assign w_last = (r_idx == LASTIDX);
    assign w_done = w_acc & w_last;
    // Refill whenever the holding slot is empty or is being emptied this cycle.
    assign w_pop  = ~flush_i & ~rd_empty_i & (~r_have | w_done);

    assign w_k = msb_first_p ? (LASTIDX - r_idx) : r_idx;

    always_comb begin
        w_slice = r_word[int'(w_k) * owidth_p +: owidth_p];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
        if (!src_rst_an_i) begin
            r_word <= '0;
            r_idx  <= '0;
            r_have <= 1'b0;
        end else if (flush_i) begin
            r_idx  <= '0;
            r_have <= 1'b0;
        end else if (w_pop) begin
            r_word <= rd_data_i;
            r_idx  <= '0;
            r_have <= 1'b1;
        end else if (w_done) begin
            r_idx  <= '0;
            r_have <= 1'b0;
        end else if (w_acc) begin
            r_idx  <= r_idx + IDXW'(1);
        end
    end

    assign rd_en_o     = w_pop;
    assign out_valid_o = r_have;
    assign out_data_o  = w_slice;
    assign out_last_o  = w_last;
    assign busy_o      = r_have;

endmodule

// File: tb/tb_ucdp_sfifo_unpack.sv
// Directed self-checking bench for ucdp_sfifo_unpack with a queue-based FIFO
// model and a second instance exercising msb-first slice order.
module tb_ucdp_sfifo_unpack;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_empty;
    logic        ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    logic        m_rd_en;
    logic [31:0] m_rd_data;
    logic        m_rd_empty;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_busy;

    logic [31:0] fifo[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    ucdp_sfifo_unpack #(.dwidth_p(32), .owidth_p(8), .msb_first_p(1'b0)) dut (
        .src_clk_i    (clk),
        .src_rst_an_i (rst_n),
        .flush_i      (flush),
        .rd_en_o      (rd_en),
        .rd_data_i    (rd_data),
        .rd_empty_i   (rd_empty),
        .out_valid_o  (out_valid),
        .out_ready_i  (ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .busy_o       (busy)
    );

    ucdp_sfifo_unpack #(.dwidth_p(32), .owidth_p(8), .msb_first_p(1'b1)) dut_msb (
        .src_clk_i    (clk),
        .src_rst_an_i (rst_n),
        .flush_i      (1'b0),
        .rd_en_o      (m_rd_en),
        .rd_data_i    (m_rd_data),
        .rd_empty_i   (m_rd_empty),
        .out_valid_o  (m_valid),
        .out_ready_i  (1'b1),
        .out_data_o   (m_data),
        .out_last_o   (m_last),
        .busy_o       (m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic refresh();
        rd_empty = (fifo.size() == 0);
        rd_data  = rd_empty ? 32'h0 : fifo[0];
    endtask

    // Let combinational outputs settle, then compare the main instance.
    task automatic chk(input string tag, input bit v, input logic [7:0] d,
                       input bit l, input bit re);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".busy"},  32'(busy),      32'(v));
        check({tag, ".rd_en"}, 32'(rd_en),     32'(re));
        if (v) begin
            check({tag, ".data"}, 32'(out_data), 32'(d));
            check({tag, ".last"}, 32'(out_last), 32'(l));
        end
    endtask

    // One clock: the FIFO model pops if rd_en was high going into the edge.
    task automatic cyc();
        logic pop;
        pop = rd_en;
        @(posedge clk);
        if (pop) void'(fifo.pop_front());
        #1;
        refresh();
    endtask

    logic [7:0] msb_exp [4];
    logic [7:0] fl_exp  [4];

    initial begin
        msb_exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        fl_exp  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rst_n      = 1'b0;
        flush      = 1'b0;
        ready      = 1'b1;
        m_rd_data  = 32'h0;
        m_rd_empty = 1'b1;
        refresh();

        // Reset state
        #2;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data",  32'(out_data),  32'd0);
        check("rst.last",  32'(out_last),  32'd0);
        check("rst.busy",  32'(busy),      32'd0);
        check("rst.rd_en", 32'(rd_en),     32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc();

        // Idle with an empty FIFO
        for (int i = 0; i < 10; i++) begin
            chk("idle", 1'b0, 8'h00, 1'b0, 1'b0);
            cyc();
        end

        // Two words back to back, no bubble at the word boundary
        fifo.push_back(32'h44332211);
        fifo.push_back(32'h88776655);
        refresh();
        chk("stream.c0", 1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("stream", 1'b1, 8'(8'h11 * (i + 1)), (i == 3) || (i == 7), i == 3);
            cyc();
        end
        chk("stream.end", 1'b0, 8'h00, 1'b0, 1'b0);

        // MSB-first ordering
        m_rd_data  = 32'hA1B2C3D4;
        m_rd_empty = 1'b0;
        #1;
        check("msb.rd_en", 32'(m_rd_en), 32'd1);
        @(posedge clk);
        #1 m_rd_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("msb.valid", 32'(m_valid), 32'd1);
            check("msb.data",  32'(m_data),  32'(msb_exp[i]));
            check("msb.last",  32'(m_last),  32'(i == 3));
            @(posedge clk);
            #1;
        end
        check("msb.idle", 32'(m_busy), 32'd0);
        cyc();

        // Backpressure holds slice 0, no pop until the last slice is taken
        fifo.push_back(32'h44332211);
        ready = 1'b0;
        refresh();
        chk("bp.c0", 1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        fifo.push_back(32'h88776655);
        refresh();
        for (int i = 0; i < 3; i++) begin
            chk("bp.hold", 1'b1, 8'h11, 1'b0, 1'b0);
            cyc();
        end
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp.drain", 1'b1, 8'(8'h11 * (i + 1)), (i == 3) || (i == 7), i == 3);
            cyc();
        end
        chk("bp.end", 1'b0, 8'h00, 1'b0, 1'b0);

        // Flush while slice 1 is stalled
        fifo.push_back(32'h44332211);
        fifo.push_back(32'hDDCCBBAA);
        refresh();
        chk("fl.c0", 1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        chk("fl.s0", 1'b1, 8'h11, 1'b0, 1'b0);
        cyc();
        ready = 1'b0;
        flush = 1'b1;
        chk("fl.flush", 1'b1, 8'h22, 1'b0, 1'b0);
        cyc();
        flush = 1'b0;
        chk("fl.after", 1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fl.next", 1'b1, fl_exp[i], i == 3, 1'b0);
            cyc();
        end
        chk("fl.end", 1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-word at slice index 2
        fifo.push_back(32'h44332211);
        fifo.push_back(32'h88776655);
        refresh();
        chk("ar.c0", 1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        chk("ar.s0", 1'b1, 8'h11, 1'b0, 1'b0);
        cyc();
        chk("ar.s1", 1'b1, 8'h22, 1'b0, 1'b0);
        cyc();
        ready = 1'b0;
        chk("ar.s2", 1'b1, 8'h33, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.busy",  32'(busy),      32'd0);
        check("ar.data",  32'(out_data),  32'd0);
        check("ar.last",  32'(out_last),  32'd0);
        rst_n = 1'b1;
        #1;
        check("ar.repop", 32'(rd_en), 32'd1);
        cyc();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ar.next", 1'b1, 8'(8'h55 + 8'h11 * i), i == 3, 1'b0);
            cyc();
        end
        chk("ar.end", 1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ucdp_sfifo_unpack.md
Name: ucdp_sfifo_unpack

Overview:
Downstream consumer stage for the synchronous FIFO. It pops wide words from the FIFO read port and serialises each word into ratio_p = dwidth_p/owidth_p narrow slices on a valid/ready output stream. It holds one word locally, so FIFO pops overlap with slice output and sustain one slice per cycle.

Parameters:
dwidth_p, 32, FIFO word width; must be an integer multiple of owidth_p.
owidth_p, 8, output slice width; ratio_p = dwidth_p/owidth_p, and ratio_p >= 1.
msb_first_p, 0, 0: slice 0 = word[owidth_p-1:0] goes out first; 1: most significant slice goes out first.

Ports:
src_clk_i  input  1  clock
src_rst_an_i  input  1  Async Reset (Low-Active)
flush_i  input  1  synchronous discard of the held word and slice index
rd_en_o  output  1  FIFO pop strobe; connects to the FIFO rd_en_i
rd_data_i  input  dwidth_p  FIFO read data; valid combinationally while rd_empty_i=0
rd_empty_i  input  1  FIFO empty flag
out_valid_o  output  1  slice valid
out_ready_i  input  1  slice accepted when out_valid_o & out_ready_i
out_data_o  output  owidth_p  current slice
out_last_o  output  1  current slice is the final slice of its word
busy_o  output  1  a word is held (equals out_valid_o)

Behaviour:
- Reset is asynchronous and active-low; clock is src_clk_i. Reset values: word_r=0, idx_r=0, have_r=0, so out_valid_o=0, out_data_o=0, out_last_o=0 (ratio_p>1), busy_o=0.
- idx_r is max(1,$clog2(ratio_p)) bits and counts 0..ratio_p-1. lastidx = ratio_p-1.
- Slice selection: slice k = word_r[k*owidth_p +: owidth_p]. k = idx_r when msb_first_p=0. k = lastidx-idx_r when msb_first_p=1.
- out_valid_o = have_r.
- out_last_o = (idx_r == lastidx); it is 1 whenever ratio_p=1.
- Accept: acc = have_r & out_ready_i.
- Word done: done = acc & (idx_r == lastidx).
- Pop: rd_en_o = ~flush_i & ~rd_empty_i & (~have_r | done). rd_en_o is never asserted while rd_empty_i=1.
- On a pop: word_r <= rd_data_i, idx_r <= 0, have_r <= 1.
- On done without a pop: have_r <= 0, idx_r <= 0, word_r is retained. Retained data is don't-care while out_valid_o=0.
- On acc & ~done: idx_r <= idx_r + 1.
- Without acc: all state holds. out_data_o and out_last_o must stay stable while out_valid_o=1 and out_ready_i=0.
- Latency: when FIFO goes non-empty and the block is idle, rd_en_o=1 in that same cycle and out_valid_o=1 in the next cycle.
- Throughput: with a non-empty FIFO and out_ready_i held at 1, one slice per cycle with no bubble at word boundaries. The next word is popped in the cycle the last slice is accepted.
- flush_i has priority over everything. Next state is have_r=0, idx_r=0. rd_en_o is forced to 0 in the flush cycle. A slice handshaked in the flush cycle counts as accepted, but the rest of the word is dropped. FIFO contents are untouched.
- Reset mid-word: the held word is lost immediately and outputs go to reset values asynchronously.
- ratio_p=1: behaves as a one-entry register stage. A pop occurs on every accept when the FIFO is non-empty.
- Elaboration error if dwidth_p % owidth_p != 0 or owidth_p < 1.

Test Plan:
- Reset, FIFO empty, ready=1, 10 cycles -> rd_en_o=0, out_valid_o=0, busy_o=0 throughout.
- Defaults, FIFO holds 0x44332211 then 0x88776655, ready=1 -> rd_en_o pulses in cycles 0 and 4. Slices 11,22,33,44,55,66,77,88 appear on consecutive cycles 1..8. out_last_o=1 on 44 and 88.
- msb_first_p=1, word 0xA1B2C3D4 -> slices A1,B2,C3,D4. out_last_o=1 on D4.
- Backpressure: word 0x44332211, ready=0 for 3 cycles after valid, then 1 -> out_data_o stays 11 and idx holds. Then 22,33,44 follow. No pop until 44 is accepted.
- flush_i pulsed while slice 22 is presented and ready=0, FIFO non-empty -> next cycle out_valid_o=0, rd_en_o=0 during flush. The following cycle pops the next word and restarts at its slice 0.
- Async reset asserted mid-word at idx 2 -> out_valid_o drops immediately. After release, the next FIFO word starts at slice 0.
